// File: rtl/icache.sv
// Direct-mapped, one-word-per-line instruction cache between the fetch unit and
// the memory interface inst1 port. Hits return in the same cycle; misses fetch one word.
module icache #(
  parameter int INDEX_BITS = 6,
  parameter int TAG_BITS   = 30 - INDEX_BITS
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        rob_clear,
  input  logic        if_valid,
  input  logic [31:0] if_addr,
  output logic        if_ready,
  output logic [31:0] if_inst,
  output logic        mem_valid,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_result,
  input  logic        mem_ready
);

  localparam int LINES = 1 << INDEX_BITS;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    MISS = 2'b01
  } state_t;

  state_t state, state_nxt;

  logic [LINES-1:0]    valid_bits;
  logic [TAG_BITS-1:0] tag_mem  [LINES];
  logic [31:0]         data_mem [LINES];

  // Word address of the outstanding miss; the byte offset is always zero.
  logic [31:2]           miss_word;
  logic [INDEX_BITS-1:0] req_idx;
  logic [TAG_BITS-1:0]   req_tag;
  logic [INDEX_BITS-1:0] fill_idx;
  logic [TAG_BITS-1:0]   fill_tag;
  logic                  hit;
  logic                  fill;
  logic                  start_miss;
  logic                  unused_byte_offset;

  assign req_idx            = if_addr[INDEX_BITS+1:2];
  assign req_tag            = if_addr[31:INDEX_BITS+2];
  assign fill_idx           = miss_word[INDEX_BITS+1:2];
  assign fill_tag           = miss_word[31:INDEX_BITS+2];
  assign unused_byte_offset = ^if_addr[1:0];

  assign hit = if_valid && valid_bits[req_idx] && (tag_mem[req_idx] == req_tag);

  // A flush overrides everything, including a frozen pipeline.
  // NOTE: every output of this block gets a default first so no path infers a latch.
  always_comb begin
    state_nxt  = state;
    if_ready   = 1'b0;
    if_inst    = 32'h0;
    fill       = 1'b0;
    start_miss = 1'b0;
    if (rob_clear) begin
      state_nxt = IDLE;
    end else if (rdy_in) begin
      unique case (state)
        IDLE: begin
          if (hit) begin
            if_ready = 1'b1;
            if_inst  = data_mem[req_idx];
          end else if (if_valid) begin
            start_miss = 1'b1;
            state_nxt  = MISS;
          end
        end
        MISS: begin
          if (mem_ready) begin
            fill      = 1'b1;
            if_ready  = 1'b1;
            if_inst   = mem_result;
            state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state      <= IDLE;
      miss_word  <= '0;
      valid_bits <= '0;
    end else begin
      state <= state_nxt;
      if (start_miss) miss_word <= if_addr[31:2];
      if (fill) valid_bits[fill_idx] <= 1'b1;
    end
  end

  // NOTE: tag and data arrays are deliberately not reset; the valid bits gate every use.
  always_ff @(posedge clk_in) begin
    if (fill) begin
      tag_mem[fill_idx]  <= fill_tag;
      data_mem[fill_idx] <= mem_result;
    end
  end

  assign mem_valid = (state == MISS);
  assign mem_addr  = {miss_word, 2'b00};

endmodule
